uart_cfg_rx: RTL

Parametrised UART configuration receiver, the successor to the current 5-register config shift receiver. It receives byte frames at a fixed bit period, with optional even parity and stop-bit checking. Frames are assembled into 3-byte packets {addr, value, checksum}, and a valid packet writes one of PAR_NUM config registers by address instead of by rotating position. It sits between the host UART pin and the controller's config consumers (ref_gen, phase_shift, ocd_lvl, inter_freq, inter_duty, …).

---
 rtl/uart_cfg_rx.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_cfg_rx.sv
// UART config receiver: frames LSB-first bytes, groups them into {addr, value, checksum} packets and writes addressed config registers.
// Latency: a register write (upd_stb) appears two clocks after the stop-bit sample of the checksum byte; frame errors one clock after.
// Backpressure: none; the UART line cannot be stalled, so every decision is a one-cycle pulse and bad bytes/packets are dropped.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   uart_data  asynchronous UART line, idle high
//   par_regs   flat config bus, register i at [i*DATA_BITS +: DATA_BITS]
//   upd_stb    one-cycle pulse when a register is written
//   upd_idx    index of the last written register
//   err_frame  one-cycle pulse, stop bit sampled low
//   err_parity one-cycle pulse, even-parity mismatch (only with PARITY_EN)
//   err_pkt    one-cycle pulse, bad checksum, address out of range or intra-packet timeout
module uart_cfg_rx #(
    parameter int CLK_PER_BIT  = 52,
    parameter int DATA_BITS    = 8,
    parameter int PAR_NUM      = 5,
    parameter int PARITY_EN    = 0,
    parameter int TIMEOUT_BITS = 20,
    localparam int IDX_W       = (PAR_NUM > 1) ? $clog2(PAR_NUM) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         uart_data,
    output logic [PAR_NUM*DATA_BITS-1:0] par_regs,
    output logic                         upd_stb,
    output logic [IDX_W-1:0]             upd_idx,
    output logic                         err_frame,
    output logic                         err_parity,
    output logic                         err_pkt
);

    // Bit-period timing
    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLK_PER_BIT - 1);

    // Data-bit index within a frame
    localparam int DCW = $clog2(DATA_BITS);
    localparam logic [DCW-1:0] LAST_BIT = DCW'(DATA_BITS - 1);

    // Intra-packet idle limit, in clock cycles
    localparam int TMO_CYC = TIMEOUT_BITS * CLK_PER_BIT;
    localparam int TW = $clog2(TMO_CYC + 1);
    localparam logic [TW-1:0] TMO_LIM = TW'(TMO_CYC);

    // One extra bit so PAR_NUM = 2**DATA_BITS is representable
    localparam logic [DATA_BITS:0] PAR_LIM = (DATA_BITS + 1)'(PAR_NUM);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } frm_state_t;

    // ------------------------------------------------------------------
    // Input synchronizer. sync_q[1] is the synchronized line; s_prev_q is
    // its previous value, used only for falling-edge detection.
    // ------------------------------------------------------------------
    logic [1:0] sync_q;
    logic       s_prev_q;
    logic       s;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= 2'b11;
            s_prev_q <= 1'b1;
        end else begin
            sync_q   <= {sync_q[0], uart_data};
            s_prev_q <= sync_q[1];
        end
    end

    assign s = sync_q[1];

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    frm_state_t           state_q;
    logic [CW-1:0]        bit_cnt_q;
    logic [DCW-1:0]       dbit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_bad_q;
    logic                 byte_vld_q;
    logic                 frm_err_q;
    logic                 par_err_q;
    logic                 start_det;

    // A start is only recognised from IDLE; a line that stays low after a
    // bad stop bit produces no new edge, hence no repeated errors.
    assign start_det = (state_q == S_IDLE) && s_prev_q && !s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            dbit_q     <= '0;
            shift_q    <= '0;
            par_bad_q  <= 1'b0;
            byte_vld_q <= 1'b0;
            frm_err_q  <= 1'b0;
            par_err_q  <= 1'b0;
        end else begin
            byte_vld_q <= 1'b0;
            frm_err_q  <= 1'b0;
            par_err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_det) begin
                        state_q   <= S_START;
                        bit_cnt_q <= HALF_M1;
                    end
                end
                S_START: begin
                    if (bit_cnt_q == '0) begin
                        if (s) begin
                            // Glitch shorter than half a bit: silently ignore
                            state_q <= S_IDLE;
                        end else begin
                            state_q   <= S_DATA;
                            bit_cnt_q <= FULL_M1;
                            dbit_q    <= '0;
                            par_bad_q <= 1'b0;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q - 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_cnt_q == '0) begin
                        // LSB first: after DATA_BITS shifts bit 0 is the first bit received
                        shift_q   <= {s, shift_q[DATA_BITS-1:1]};
                        bit_cnt_q <= FULL_M1;
                        if (dbit_q == LAST_BIT) begin
                            state_q <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end else begin
                            dbit_q <= dbit_q + 1'b1;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q - 1'b1;
                    end
                end
                S_PARITY: begin
                    if (bit_cnt_q == '0) begin
                        // Even parity: the parity bit equals the XOR of the data bits
                        par_bad_q <= s ^ (^shift_q);
                        bit_cnt_q <= FULL_M1;
                        state_q   <= S_STOP;
                    end else begin
                        bit_cnt_q <= bit_cnt_q - 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_cnt_q == '0) begin
                        // Leave mid stop bit so the next start edge is not missed.
                        // A framing error masks any parity error.
                        state_q <= S_IDLE;
                        if (!s) begin
                            frm_err_q <= 1'b1;
                        end else if (par_bad_q) begin
                            par_err_q <= 1'b1;
                        end else begin
                            byte_vld_q <= 1'b1;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Packet parser and config registers. The received byte stays in
    // shift_q until the next frame's data bits, so it is read directly.
    // ------------------------------------------------------------------
    logic [1:0]                   bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0]         addr_q, addr_d;
    logic [DATA_BITS-1:0]         val_q, val_d;
    logic [TW-1:0]                tcnt_q, tcnt_d;
    logic [PAR_NUM*DATA_BITS-1:0] par_regs_q, par_regs_d;
    logic                         upd_stb_q, upd_stb_d;
    logic [IDX_W-1:0]             upd_idx_q, upd_idx_d;
    logic                         err_pkt_q, err_pkt_d;
    logic                         addr_ok;
    logic                         csum_ok;
    logic                         tmo_hit;

    assign addr_ok = ({1'b0, addr_q} < PAR_LIM);
    assign csum_ok = (shift_q == (addr_q ^ val_q));
    // Only counts between bytes of a started packet; frozen while a frame is in flight
    assign tmo_hit = (state_q == S_IDLE) && (bcnt_q != 2'd0) && (tcnt_q == TMO_LIM);

    always_comb begin
        bcnt_d     = bcnt_q;
        addr_d     = addr_q;
        val_d      = val_q;
        tcnt_d     = tcnt_q;
        par_regs_d = par_regs_q;
        upd_stb_d  = 1'b0;
        upd_idx_d  = upd_idx_q;
        err_pkt_d  = 1'b0;

        // Idle-gap counter
        if (start_det || (bcnt_q == 2'd0) || tmo_hit) begin
            tcnt_d = '0;
        end else if (state_q == S_IDLE) begin
            tcnt_d = tcnt_q + 1'b1;
        end

        if (frm_err_q || par_err_q) begin
            // A corrupted byte breaks packet alignment; restart at addr
            bcnt_d = 2'd0;
        end else if (byte_vld_q) begin
            case (bcnt_q)
                2'd0: begin
                    addr_d = shift_q;
                    bcnt_d = 2'd1;
                end
                2'd1: begin
                    val_d  = shift_q;
                    bcnt_d = 2'd2;
                end
                default: begin
                    bcnt_d = 2'd0;
                    if (csum_ok && addr_ok) begin
                        for (int i = 0; i < PAR_NUM; i++) begin
                            if (addr_q == DATA_BITS'(i)) begin
                                par_regs_d[i*DATA_BITS +: DATA_BITS] = val_q;
                            end
                        end
                        upd_stb_d = 1'b1;
                        upd_idx_d = addr_q[IDX_W-1:0];
                    end else begin
                        err_pkt_d = 1'b1;
                    end
                end
            endcase
        end else if (tmo_hit) begin
            bcnt_d    = 2'd0;
            err_pkt_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt_q     <= 2'd0;
            addr_q     <= '0;
            val_q      <= '0;
            tcnt_q     <= '0;
            par_regs_q <= '0;
            upd_stb_q  <= 1'b0;
            upd_idx_q  <= '0;
            err_pkt_q  <= 1'b0;
        end else begin
            bcnt_q     <= bcnt_d;
            addr_q     <= addr_d;
            val_q      <= val_d;
            tcnt_q     <= tcnt_d;
            par_regs_q <= par_regs_d;
            upd_stb_q  <= upd_stb_d;
            upd_idx_q  <= upd_idx_d;
            err_pkt_q  <= err_pkt_d;
        end
    end

    assign par_regs   = par_regs_q;
    assign upd_stb    = upd_stb_q;
    assign upd_idx    = upd_idx_q;
    assign err_frame  = frm_err_q;
    assign err_parity = par_err_q;
    assign err_pkt    = err_pkt_q;

endmodule
